// File: rtl/axi4_lite_master_read_timeout_monitor.sv
// Passive AXI4-Lite read-channel checker: AR/R stall timers, outstanding tracking, stability checks.
// Define AXI4LITE_RD_MON_STATS_EN to add the lat_max / rd_count statistics outputs.
module axi4_lite_master_read_timeout_monitor #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MAX_DELAY_READY  = 16,
  parameter int MAX_DELAY_RVALID = 10,
  parameter int MAX_DELAY_RREADY = 16,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  err_clr,
  output logic [7:0]            err_flags,
  output logic [3:0]            outstanding,
  output logic                  rd_done
`ifdef AXI4LITE_RD_MON_STATS_EN
  ,
  output logic [7:0]            lat_max,
  output logic [15:0]           rd_count
`endif
);

  localparam int ARC_W = $clog2(MAX_DELAY_READY + 1);
  localparam int RVC_W = $clog2(MAX_DELAY_RVALID + 1);
  localparam int RRC_W = $clog2(MAX_DELAY_RREADY + 1);
  localparam logic [ARC_W-1:0] AR_MAX  = ARC_W'(MAX_DELAY_READY);
  localparam logic [RVC_W-1:0] RV_MAX  = RVC_W'(MAX_DELAY_RVALID);
  localparam logic [RRC_W-1:0] RR_MAX  = RRC_W'(MAX_DELAY_RREADY);
  localparam logic [3:0]       OUT_MAX = 4'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE, AR_STALL} ar_state_t;
  typedef enum logic {R_IDLE, R_STALL} r_state_t;

  ar_state_t             ar_state, ar_state_nxt;
  r_state_t              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_nxt;
  logic [2:0]            ar_prot_q, ar_prot_nxt;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_nxt;
  logic [1:0]            r_resp_q, r_resp_nxt;
  logic [ARC_W-1:0]      ar_cnt, ar_cnt_inc, ar_cnt_nxt;
  logic [RVC_W-1:0]      rv_cnt, rv_cnt_inc, rv_cnt_nxt;
  logic [RRC_W-1:0]      rr_cnt, rr_cnt_inc, rr_cnt_nxt;
  logic [3:0]            outstanding_nxt;
  logic [7:0]            ev, err_nxt;
  logic                  arh, rh, ar_stall_cyc, r_stall_cyc, rv_idle_cyc;

  // valid/ready: a transfer happens on any cycle with valid&ready; valid&!ready is a stall cycle.
  always_comb begin
    arh          = arvalid & arready;
    rh           = rvalid & rready;
    ar_stall_cyc = arvalid & ~arready;
    r_stall_cyc  = rvalid & ~rready;
    rv_idle_cyc  = (outstanding != 4'd0) && !rvalid;
    ar_state_nxt = ar_state;
    r_state_nxt  = r_state;
    ar_addr_nxt  = ar_addr_q;
    ar_prot_nxt  = ar_prot_q;
    r_data_nxt   = r_data_q;
    r_resp_nxt   = r_resp_q;
    ev           = '0;

    case (ar_state)
      AR_IDLE: begin
        if (ar_stall_cyc) begin
          ar_state_nxt = AR_STALL;
          ar_addr_nxt  = araddr;
          ar_prot_nxt  = arprot;
        end
      end
      AR_STALL: begin
        if (!arvalid) begin
          ev[1]        = 1'b1;
          ar_state_nxt = AR_IDLE;
        end else begin
          if (araddr != ar_addr_q || arprot != ar_prot_q) ev[2] = 1'b1;
          if (arready) ar_state_nxt = AR_IDLE;
        end
      end
      default: ar_state_nxt = AR_IDLE;
    endcase

    case (r_state)
      R_IDLE: begin
        if (r_stall_cyc) begin
          r_state_nxt = R_STALL;
          r_data_nxt  = rdata;
          r_resp_nxt  = rresp;
        end
      end
      R_STALL: begin
        if (!rvalid) begin
          ev[5]       = 1'b1;
          r_state_nxt = R_IDLE;
        end else begin
          if (rdata != r_data_q || rresp != r_resp_q) ev[5] = 1'b1;
          if (rready) r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase

    // Counters saturate at their limit so the flag keeps re-asserting while the stall persists.
    ar_cnt_inc = (ar_cnt == AR_MAX) ? ar_cnt : ar_cnt + ARC_W'(1);
    rv_cnt_inc = (rv_cnt == RV_MAX) ? rv_cnt : rv_cnt + RVC_W'(1);
    rr_cnt_inc = (rr_cnt == RR_MAX) ? rr_cnt : rr_cnt + RRC_W'(1);
    ar_cnt_nxt = ar_stall_cyc ? ar_cnt_inc : '0;
    rv_cnt_nxt = rv_idle_cyc  ? rv_cnt_inc : '0;
    rr_cnt_nxt = r_stall_cyc  ? rr_cnt_inc : '0;
    if (ar_stall_cyc && ar_cnt_inc == AR_MAX) ev[0] = 1'b1;
    if (rv_idle_cyc  && rv_cnt_inc == RV_MAX) ev[3] = 1'b1;
    if (r_stall_cyc  && rr_cnt_inc == RR_MAX) ev[4] = 1'b1;
    if (rvalid && outstanding == 4'd0)        ev[6] = 1'b1;

    outstanding_nxt = outstanding;
    if (arh && !rh) begin
      if (outstanding == OUT_MAX) ev[7] = 1'b1;
      else outstanding_nxt = outstanding + 4'd1;
    end else if (rh && !arh && outstanding != 4'd0) begin
      outstanding_nxt = outstanding - 4'd1;
    end

    err_nxt = (err_clr ? 8'h00 : err_flags) | ev;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_state    <= AR_IDLE;
      r_state     <= R_IDLE;
      ar_addr_q   <= '0;
      ar_prot_q   <= '0;
      r_data_q    <= '0;
      r_resp_q    <= '0;
      ar_cnt      <= '0;
      rv_cnt      <= '0;
      rr_cnt      <= '0;
      outstanding <= '0;
      err_flags   <= '0;
      rd_done     <= 1'b0;
    end else begin
      ar_state    <= ar_state_nxt;
      r_state     <= r_state_nxt;
      ar_addr_q   <= ar_addr_nxt;
      ar_prot_q   <= ar_prot_nxt;
      r_data_q    <= r_data_nxt;
      r_resp_q    <= r_resp_nxt;
      ar_cnt      <= ar_cnt_nxt;
      rv_cnt      <= rv_cnt_nxt;
      rr_cnt      <= rr_cnt_nxt;
      outstanding <= outstanding_nxt;
      err_flags   <= err_nxt;
      rd_done     <= rh;
    end
  end

`ifdef AXI4LITE_RD_MON_STATS_EN
  logic [15:0] ts_now;
  logic [15:0] ts_fifo [4];
  logic [1:0]  ts_wr, ts_rd;
  logic [2:0]  ts_cnt;
  logic        ts_push, ts_pop;
  logic [15:0] lat_raw;
  logic [7:0]  lat_sat;

  // Oldest read is answered first, so a FIFO of AR timestamps pairs each R with its AR.
  always_comb begin
    ts_pop  = rh && (ts_cnt != 3'd0);
    ts_push = arh && ((ts_cnt != 3'd4) || ts_pop);
    lat_raw = ts_now - ts_fifo[ts_rd];
    lat_sat = (lat_raw[15:8] != 8'd0) ? 8'hFF : lat_raw[7:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ts_now   <= '0;
      ts_wr    <= '0;
      ts_rd    <= '0;
      ts_cnt   <= '0;
      lat_max  <= '0;
      rd_count <= '0;
      for (int i = 0; i < 4; i++) ts_fifo[i] <= '0;
    end else begin
      ts_now <= ts_now + 16'd1;
      if (ts_push) begin
        ts_fifo[ts_wr] <= ts_now;
        ts_wr          <= ts_wr + 2'd1;
      end
      if (ts_pop) begin
        ts_rd <= ts_rd + 2'd1;
        if (lat_sat > lat_max) lat_max <= lat_sat;
      end
      case ({ts_push, ts_pop})
        2'b10:   ts_cnt <= ts_cnt + 3'd1;
        2'b01:   ts_cnt <= ts_cnt - 3'd1;
        default: ts_cnt <= ts_cnt;
      endcase
      if (rh) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_master_read_timeout_monitor.sv
// Bench for axi4_lite_master_read_timeout_monitor: directed scenarios plus randomized traffic
// checked cycle-by-cycle against a behavioural model through an expected-value queue.
module tb_axi4_lite_master_read_timeout_monitor;
  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int MAX_DELAY_READY  = 16;
  localparam int MAX_DELAY_RVALID = 10;
  localparam int MAX_DELAY_RREADY = 16;
  localparam int MAX_OUTSTANDING  = 4;
`ifdef AXI4LITE_RD_MON_STATS_EN
  localparam int EW = 37;
`else
  localparam int EW = 13;
`endif

  logic                  aclk    = 1'b0;
  logic                  areset  = 1'b1;
  logic                  arvalid = 1'b0;
  logic                  arready = 1'b0;
  logic [ADDR_WIDTH-1:0] araddr  = '0;
  logic [2:0]            arprot  = '0;
  logic                  rvalid  = 1'b0;
  logic                  rready  = 1'b0;
  logic [DATA_WIDTH-1:0] rdata   = '0;
  logic [1:0]            rresp   = '0;
  logic                  err_clr = 1'b0;
  logic [7:0]            err_flags;
  logic [3:0]            outstanding;
  logic                  rd_done;
`ifdef AXI4LITE_RD_MON_STATS_EN
  logic [7:0]            lat_max;
  logic [15:0]           rd_count;
`endif

  axi4_lite_master_read_timeout_monitor #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .MAX_DELAY_READY(MAX_DELAY_READY), .MAX_DELAY_RVALID(MAX_DELAY_RVALID),
    .MAX_DELAY_RREADY(MAX_DELAY_RREADY), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .aclk(aclk), .areset(areset), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .err_clr(err_clr), .err_flags(err_flags),
    .outstanding(outstanding), .rd_done(rd_done)
`ifdef AXI4LITE_RD_MON_STATS_EN
    , .lat_max(lat_max), .rd_count(rd_count)
`endif
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  // behavioural reference: run lengths, a plain integer outstanding count and a timestamp queue
  logic [7:0]            m_flags;
  int                    m_outs, ar_run, r_run, idle_run;
  bit                    in_ar_stall, in_r_stall, m_rd_done;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [2:0]            lat_prot;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [1:0]            lat_resp;
  int                    ts_q[$];
  int                    m_lat_max, m_rd_count, cyc;

  logic [ADDR_WIDTH-1:0] cur_addr = 32'h100;
  logic [2:0]            cur_prot = 3'd0;
  logic [DATA_WIDTH-1:0] cur_data = 32'hCAFE_0001;
  logic [1:0]            cur_resp = 2'd0;

  function automatic void model_step(input bit av, ar, input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [2:0] prot, input bit rv, rr,
                                     input logic [DATA_WIDTH-1:0] data, input logic [1:0] resp,
                                     input bit clr, rst);
    bit arh, rh, ar_st, r_st;
    logic [7:0] ev;
    int lat;
    arh = av && ar;  rh = rv && rr;
    ar_st = av && !ar;  r_st = rv && !rr;
    if (rst) begin
      m_flags = '0; m_outs = 0; ar_run = 0; r_run = 0; idle_run = 0;
      in_ar_stall = 0; in_r_stall = 0; m_rd_done = 0;
      lat_addr = '0; lat_prot = '0; lat_data = '0; lat_resp = '0;
      ts_q.delete(); m_lat_max = 0; m_rd_count = 0;
    end else begin
      ev = '0;
      ev[0] = ar_st && (ar_run + 1 >= MAX_DELAY_READY);
      ev[1] = in_ar_stall && !av;
      ev[2] = in_ar_stall && av && (addr != lat_addr || prot != lat_prot);
      ev[3] = (m_outs > 0) && !rv && (idle_run + 1 >= MAX_DELAY_RVALID);
      ev[4] = r_st && (r_run + 1 >= MAX_DELAY_RREADY);
      ev[5] = in_r_stall && (!rv || data != lat_data || resp != lat_resp);
      ev[6] = rv && (m_outs == 0);
      ev[7] = arh && !rh && (m_outs == MAX_OUTSTANDING);
      m_flags  = (clr ? 8'h00 : m_flags) | ev;
      idle_run = ((m_outs > 0) && !rv) ? idle_run + 1 : 0;
      ar_run   = ar_st ? ar_run + 1 : 0;
      r_run    = r_st ? r_run + 1 : 0;
      if (ar_st && !in_ar_stall) begin lat_addr = addr; lat_prot = prot; end
      if (r_st && !in_r_stall) begin lat_data = data; lat_resp = resp; end
      in_ar_stall = ar_st;
      in_r_stall  = r_st;
      if (arh && !rh && m_outs < MAX_OUTSTANDING) m_outs++;
      if (rh && !arh && m_outs > 0) m_outs--;
      m_rd_done = rh;
      if (rh && ts_q.size() > 0) begin
        lat = cyc - ts_q.pop_front();
        if (lat > 255) lat = 255;
        if (lat > m_lat_max) m_lat_max = lat;
      end
      if (arh && ts_q.size() < 4) ts_q.push_back(cyc);
      if (rh) m_rd_count = (m_rd_count + 1) % 65536;
    end
    cyc++;
  endfunction

  function automatic logic [EW-1:0] pack_exp();
`ifdef AXI4LITE_RD_MON_STATS_EN
    return {m_flags, 4'(m_outs), m_rd_done, 8'(m_lat_max), 16'(m_rd_count)};
`else
    return {m_flags, 4'(m_outs), m_rd_done};
`endif
  endfunction

  function automatic logic [EW-1:0] pack_act();
`ifdef AXI4LITE_RD_MON_STATS_EN
    return {err_flags, outstanding, rd_done, lat_max, rd_count};
`else
    return {err_flags, outstanding, rd_done};
`endif
  endfunction

  // driver tasks
  task automatic drive(input bit av, ar, input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] prot,
                       input bit rv, rr, input logic [DATA_WIDTH-1:0] data, input logic [1:0] resp,
                       input bit clr, rst);
    @(negedge aclk);
    arvalid = av; arready = ar; araddr = addr; arprot = prot;
    rvalid = rv; rready = rr; rdata = data; rresp = resp;
    err_clr = clr; areset = rst;
    model_step(av, ar, addr, prot, rv, rr, data, resp, clr, rst);
    exp_q.push_back(pack_exp());
  endtask

  task automatic bus(input bit av, ar, rv, rr, clr);
    drive(av, ar, cur_addr, cur_prot, rv, rr, cur_data, cur_resp, clr, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, cur_addr, cur_prot, 1'b0, 1'b0, cur_data, cur_resp, 1'b0, 1'b1);
  endtask

  task automatic sample();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: one expected output vector per driven cycle
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(posedge aclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack_act();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL out_vec: got 0x%0h, expected 0x%0h (t=%0t)", a, e, $time);
        end
      end
    end
  end

  initial begin
    int pv[3];
    int pav, par, prv, prr;
    pv[0] = 5; pv[1] = 50; pv[2] = 95;

    do_reset(); sample();
    check("reset_flags", 32'(err_flags), 32'h00);
    check("reset_outstanding", 32'(outstanding), 32'd0);
    check("reset_rd_done", 32'(rd_done), 32'd0);

    // AR stall of MAX-1 cycles stays clean; MAX cycles flags AR_READY_TIMEOUT
    cur_addr = 32'h100;
    repeat (15) bus(1, 0, 0, 0, 0);
    bus(1, 1, 0, 0, 0); sample();
    check("ar_stall_15_flags", 32'(err_flags), 32'h00);
    check("ar_stall_15_outs", 32'(outstanding), 32'd1);
    do_reset();
    repeat (16) bus(1, 0, 0, 0, 0);
    bus(1, 1, 0, 0, 0); sample();
    check("ar_stall_16_flags", 32'(err_flags), 32'h01);
    check("ar_stall_16_outs", 32'(outstanding), 32'd1);

    // address change while stalled, then arvalid dropped
    do_reset();
    cur_addr = 32'h10;
    repeat (2) bus(1, 0, 0, 0, 0);
    cur_addr = 32'h14;
    bus(1, 0, 0, 0, 0); sample();
    check("ar_unstable", 32'(err_flags), 32'h04);
    bus(0, 0, 0, 0, 0); sample();
    check("arvalid_drop", 32'(err_flags), 32'h06);

    // rvalid late, err_clr, then long rready stall
    do_reset();
    bus(1, 1, 0, 0, 0);
    repeat (9) bus(0, 0, 0, 0, 0); sample();
    check("rvalid_idle_9", 32'(err_flags), 32'h00);
    bus(0, 0, 0, 0, 0); sample();
    check("rvalid_timeout", 32'(err_flags), 32'h08);
    bus(0, 0, 1, 0, 1); sample();
    check("err_clr", 32'(err_flags), 32'h00);
    repeat (14) bus(0, 0, 1, 0, 0); sample();
    check("rready_stall_15", 32'(err_flags), 32'h00);
    bus(0, 0, 1, 0, 0); sample();
    check("rready_timeout", 32'(err_flags), 32'h10);
    bus(0, 0, 1, 1, 0); sample();
    check("rd_done_pulse", 32'(rd_done), 32'd1);
    check("outs_after_rh", 32'(outstanding), 32'd0);
    bus(0, 0, 0, 0, 0); sample();
    check("rd_done_low", 32'(rd_done), 32'd0);

    // outstanding limit and same-cycle ARH/RH
    do_reset();
    repeat (4) bus(1, 1, 0, 0, 0); sample();
    check("outs_full", 32'(outstanding), 32'd4);
    check("outs_full_flags", 32'(err_flags), 32'h00);
    bus(1, 1, 0, 0, 0); sample();
    check("outs_ovf_flags", 32'(err_flags), 32'h80);
    check("outs_ovf_outs", 32'(outstanding), 32'd4);
    do_reset();
    repeat (2) bus(1, 1, 0, 0, 0);
    bus(1, 1, 1, 1, 0); sample();
    check("ar_r_same_cycle", 32'(outstanding), 32'd2);
    check("ar_r_same_flags", 32'(err_flags), 32'h00);

    // unexpected response, reset mid R stall, response after reset
    do_reset();
    bus(0, 0, 1, 0, 0); sample();
    check("r_unexpected", 32'(err_flags), 32'h40);
    bus(0, 0, 1, 0, 0);
    drive(0, 0, cur_addr, cur_prot, 1, 0, cur_data, cur_resp, 0, 1); sample();
    check("mid_reset_flags", 32'(err_flags), 32'h00);
    check("mid_reset_outs", 32'(outstanding), 32'd0);
    bus(0, 0, 1, 1, 0); sample();
    check("resp_after_reset", 32'(err_flags), 32'h40);

`ifdef AXI4LITE_RD_MON_STATS_EN
    do_reset();
    bus(1, 1, 0, 0, 0); repeat (2) bus(0, 0, 0, 0, 0); bus(0, 0, 1, 1, 0);
    bus(1, 1, 0, 0, 0); repeat (6) bus(0, 0, 0, 0, 0); bus(0, 0, 1, 1, 0);
    bus(1, 1, 0, 0, 0); repeat (4) bus(0, 0, 0, 0, 0); bus(0, 0, 1, 1, 0);
    sample();
    check("lat_max", 32'(lat_max), 32'd7);
    check("rd_count", 32'(rd_count), 32'd3);
`endif

    // randomized traffic in segments with varying valid/ready densities
    do_reset();
    for (int seg = 0; seg < 80; seg++) begin
      pav = pv[$urandom_range(0, 2)];
      par = pv[$urandom_range(0, 2)];
      prv = pv[$urandom_range(0, 2)];
      prr = pv[$urandom_range(0, 2)];
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 99) < 3) cur_addr = $urandom;
        if ($urandom_range(0, 99) < 3) cur_prot = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 99) < 3) cur_data = $urandom;
        if ($urandom_range(0, 99) < 3) cur_resp = 2'($urandom_range(0, 3));
        drive($urandom_range(0, 99) < pav, $urandom_range(0, 99) < par, cur_addr, cur_prot,
              $urandom_range(0, 99) < prv, $urandom_range(0, 99) < prr, cur_data, cur_resp,
              $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 3);
      end
    end

    @(posedge aclk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
